// File: rtl/mbe_mult_pkg.sv
// Shared types and helpers for the MBE multiplier scheduler slice.
package mbe_mult_pkg;
  localparam int OPW    = 11;
  localparam int PW     = 22;
  localparam int MAXREQ = 8;

  typedef logic signed [OPW-1:0] operand_t;
  typedef logic signed [PW-1:0]  product_t;

  // Pick requester idx's operand out of a bus zero-padded to MAXREQ slots.
  function automatic operand_t op_slice(input logic [MAXREQ*OPW-1:0] bus,
                                        input int unsigned idx);
    return operand_t'(bus[idx*OPW +: OPW]);
  endfunction
endpackage

// File: rtl/mbe_mult_arbiter_if.sv
// Requester and result handshakes of the shared multiplier scheduler.
interface mbe_mult_arbiter_if
  import mbe_mult_pkg::*;
#(
  parameter int NREQ = 4
) ();
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_a;
  logic [NREQ*OPW-1:0] req_b;
  logic                res_valid;
  logic                res_ready;
  product_t            res_p;
  logic [IDW-1:0]      res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_p, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_p, res_id
  );
endinterface

// File: rtl/mul_res_fifo.sv
// Synchronous result FIFO; async reset clears storage so the head reads zero.
module mul_res_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/mbe_mult_arbiter.sv
// Round-robin scheduler sharing one external 11x11 signed multiplier datapath
// among NREQ requesters; results return tagged, in issue order, via a FIFO.
module mbe_mult_arbiter
  import mbe_mult_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mbe_mult_arbiter_if.slave   bus,
  output operand_t            mul_a,
  output operand_t            mul_b,
  input  product_t            mul_p,
  output logic                busy
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int EW  = PW + IDW;

  logic [IDW-1:0]          rr_ptr;
  logic [IDW-1:0]          grant_idx;
  logic                    grant_any;
  logic [IDW-1:0]          s1_id;
  logic                    s1_valid;
  logic                    can_issue;
  logic                    issue;
  int unsigned             cand;
  logic [MAXREQ*OPW-1:0]   a_pad;
  logic [MAXREQ*OPW-1:0]   b_pad;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [EW-1:0]           head;

  assign a_pad = (MAXREQ*OPW)'(bus.req_a);
  assign b_pad = (MAXREQ*OPW)'(bus.req_b);

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(rr_ptr) + k) % NREQ;
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(cand);
      end
    end
  end

  // A pop in the same cycle earns no credit: the bound stays conservative.
  assign can_issue     = (32'(fifo_count) + 32'(s1_valid)) < DEPTH;
  assign issue         = grant_any & can_issue;
  assign bus.req_ready = (issue & rst_n) ? (NREQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a    <= '0;
      mul_b    <= '0;
      s1_id    <= '0;
      s1_valid <= 1'b0;
      rr_ptr   <= '0;
    end else if (issue) begin
      mul_a    <= op_slice(a_pad, 32'(grant_idx));
      mul_b    <= op_slice(b_pad, 32'(grant_idx));
      s1_id    <= grant_idx;
      s1_valid <= 1'b1;
      rr_ptr   <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  mul_res_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_valid),
    .wdata ({mul_p, s1_id}),
    .pop   (bus.res_valid & bus.res_ready),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.res_valid = ~fifo_empty;
  assign bus.res_p     = product_t'(head[EW-1:IDW]);
  assign bus.res_id    = head[IDW-1:0];
  assign busy          = s1_valid | ~fifo_empty;

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n) !(s1_valid && fifo_full));
endmodule

// File: doc/mbe_mult_arbiter.md
# mbe_mult_arbiter

Round-robin scheduler that shares one 11x11 signed MBE radix-4 multiplier datapath (partial-product generation, Dadda tree and final adder) between up to NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives registered operands into the datapath. It then captures the combinational product one cycle later and returns tagged results, in issue order, through a valid/ready output port backed by a result FIFO.

## Interface
- NREQ, 4, number of requesters (2..8); IDW = $clog2(NREQ)
- DEPTH, 4, result FIFO entries (power of 2, >= 2); also the in-flight bound
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NREQ  requester i has an operand pair
- req_ready  out  NREQ  one-hot-or-zero; requester i accepted this cycle
- req_a  in  NREQ*11  multiplicands; requester i at [11i+10:11i], signed
- req_b  in  NREQ*11  multipliers, same packing, signed
- mul_a  out  11  registered multiplicand to datapath
- mul_b  out  11  registered multiplier to datapath
- mul_p  in  22  datapath product of mul_a*mul_b, signed, combinational
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_p  out  22  signed product
- res_id  out  IDW  index of the requester that issued it
- busy  out  1  s1_valid or FIFO non-empty

## Operation
- Arbiter: pointer rr_ptr. Grant goes to the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
- can_issue = (fifo_count + s1_valid) < DEPTH. No credit is taken for a same-cycle pop; this is conservative by decision.
- req_ready[i] = grant[i] & can_issue & rst_n. It is combinational from req_valid, so requesters must not derive req_valid from req_ready.
- Issue on req_valid[i] & req_ready[i]:
  - mul_a <= req_a[i], mul_b <= req_b[i], s1_id <= i, s1_valid <= 1.
  - rr_ptr <= (i+1) mod NREQ.
- No issue: s1_valid <= 0. mul_a, mul_b and rr_ptr hold their values; operands hold to avoid toggling the datapath.
- Capture: if s1_valid, push {mul_p, s1_id} into the FIFO. A push never finds the FIFO full; an overflow is an assertion failure.
- Output: res_valid = FIFO non-empty. res_p and res_id show the FIFO head. Pop on res_valid & res_ready.
- Simultaneous push and pop: occupancy is unchanged. Pushing into an empty FIFO cannot bypass to the output in the same cycle.
- Arithmetic: two's complement throughout. Full range: -1024*-1024 = +1048576 fits in 22 bits. No saturation or truncation.
- Requester contract: hold req_valid, req_a and req_b stable until accepted. res_p and res_id stay stable while res_valid & !res_ready.

## Timing
- Reset values (rst_n low, immediate): req_ready=0, mul_a=0, mul_b=0, res_valid=0, res_p=0, res_id=0, busy=0. Internally rr_ptr=0, s1_valid=0, fifo_count=0.
- Reset mid-operation: in-flight and queued results are discarded. No res_valid after release until a new issue.
- Latency: handshake in cycle t, mul_a/mul_b valid in cycle t+1, res_valid in cycle t+2 if the FIFO was empty. Otherwise the result follows the earlier entries.
- Throughput: one issue per cycle while res_ready=1 (steady state fifo_count<=1, s1_valid=1).
- Backpressure: with res_ready=0, at most DEPTH issues are accepted, then req_ready=0.
- One requester: issues every cycle; rr_ptr moves to i+1 and wraps back.

## Structure
- Shared package mbe_mult_pkg:
  - OPW=11, PW=22
  - operand_t = logic signed [10:0]
  - product_t = logic signed [21:0]
  - the 11-bit operand slice helper
- Sub-module mul_res_fifo: synchronous FIFO, width PW+IDW, depth DEPTH, async active-low reset clearing storage and pointers. Outputs: count, empty, full.
- The arbiter, stage-1 registers and can_issue logic stay in the top module.

## Test plan
- Single request: requester 0, a=3, b=-5 → cycle t+2: res_valid=1, res_p=22'h3FFFF1 (-15), res_id=0; busy low after the pop.
- Extremes, res_ready=1:
  - a=-1024, b=-1024 → res_p=22'h100000.
  - a=1023, b=-1024 → res_p=-1047552.
  - a=0, b=-1 → 0.
- All four requesters valid continuously, res_ready=1 → grants 0,1,2,3,0,… one per cycle; results in order with matching res_id and correct products.
- Backpressure: res_ready=0, continuous requests → exactly 4 accepts, then req_ready=0. Raise res_ready → drain in issue order; issuing resumes; no loss or duplication.
- Fairness: requester 2 always valid, requester 1 raises valid → after the next grant to 2, rr_ptr=3, wraps, and 1 is granted before 2 again.
- Reset mid-operation: 2 entries in the FIFO, 1 in flight, pull rst_n low → all outputs 0 without a clock edge. After release: res_valid stays 0 and the first grant goes to requester 0.
